wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline shares one write port with a
// small FIFO of load returns, with bounded starvation of the buffered loads.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wb_en,
    input  logic [3:0]  pipe_dest,
    input  logic [31:0] pipe_value,
    input  logic        ld_valid,
    input  logic [3:0]  ld_dest,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        stall,
    output logic        wb_en,
    output logic [3:0]  wb_dest,
    output logic [31:0] wb_value,
    output logic [15:0] pend_mask
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [3:0]    mem_dest_q [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          wb_en_q, wb_en_d;
    logic [3:0]    wb_dest_q, wb_dest_d;
    logic [31:0]   wb_value_q, wb_value_d;

    logic full, empty, push, grant_ld, grant_pipe;

    assign full       = (cnt_q == CW'(DEPTH));
    assign empty      = (cnt_q == '0);
    assign ld_ready   = !full;
    assign push       = ld_valid && ld_ready;
    assign grant_ld   = !empty &&
                        (!pipe_wb_en || starve_q == SW'(STARVE_LIMIT));
    assign grant_pipe = pipe_wb_en && !grant_ld;
    assign stall      = pipe_wb_en && grant_ld;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        wb_en_d    = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_value_d = wb_value_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (grant_ld) rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({push, grant_ld})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (grant_ld || empty) begin
            starve_d = '0;
        end else if (grant_pipe && starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end

        if (grant_ld) begin
            wb_en_d    = 1'b1;
            wb_dest_d  = mem_dest_q[rd_ptr_q];
            wb_value_d = mem_data_q[rd_ptr_q];
        end else if (grant_pipe) begin
            wb_en_d    = 1'b1;
            wb_dest_d  = pipe_dest;
            wb_value_d = pipe_value;
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, AW'(i) - rd_ptr_q} < cnt_q) begin
                pend_mask[mem_dest_q[i]] = 1'b1;
            end
        end
        if (wb_en_q) pend_mask[wb_dest_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_dest_q[wr_ptr_q] <= ld_dest;
            mem_data_q[wr_ptr_q] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            wb_en_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_value_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            wb_en_q    <= wb_en_d;
            wb_dest_q  <= wb_dest_d;
            wb_value_q <= wb_value_d;
        end
    end

    assign wb_en    = wb_en_q;
    assign wb_dest  = wb_dest_q;
    assign wb_value = wb_value_q;

endmodule
